// File: rtl/multi_debouncer_pkg.sv
// Shared constants and helpers for the multi-channel debouncer.
// Provides clog2_min1() so counter widths never collapse to zero bits.
package debounce_pkg;

    // Counter width helper: a counter that only ever needs one state
    // still needs a one-bit register to stay a legal vector.
    function automatic int clog2_min1(input int n);
        int r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/multi_debouncer_if.sv
// Pad-side bundle of the multi-channel debouncer.
// i_d: raw inputs; q: debounced levels; o_rise/o_fall: edge strobes.
interface multi_debouncer_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] i_d;
    logic [N_CH-1:0] q;
    logic [N_CH-1:0] o_rise;
    logic [N_CH-1:0] o_fall;

    // Drives raw inputs, observes debounced results.
    modport master (
        output i_d,
        input  q,
        input  o_rise,
        input  o_fall
    );

    // The debouncer itself.
    modport slave (
        input  i_d,
        output q,
        output o_rise,
        output o_fall
    );
endinterface

// File: rtl/multi_debouncer_channel.sv
// One debounce channel: 2-FF synchroniser, stability counter, level, strobes.
// Ports: clk, rst (async high), i_tick (sample enable), i_d, q, o_rise, o_fall.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int   STABLE_TICKS = 16,
    parameter logic DEFAULT_D    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick,
    input  logic i_d,
    output logic q,
    output logic o_rise,
    output logic o_fall
);

    localparam int CW = clog2_min1(STABLE_TICKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= DEFAULT_D;
            sync2  <= DEFAULT_D;
            q      <= DEFAULT_D;
            cnt    <= '0;
            o_rise <= 1'b0;
            o_fall <= 1'b0;
        end else begin
            sync1  <= i_d;
            sync2  <= sync1;
            o_rise <= 1'b0;
            o_fall <= 1'b0;
            if (i_tick) begin
                if (sync2 != q) begin
                    // Last tick of the window: accept the new level and
                    // fire the matching strobe together with the q edge.
                    if (cnt == CNT_LAST) begin
                        q      <= sync2;
                        cnt    <= '0;
                        o_rise <= sync2;
                        o_fall <= ~sync2;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    // Any sample agreeing with q restarts the window.
                    cnt <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/multi_debouncer.sv
// N-channel debouncer: shared sample-tick prescaler plus N_CH channels.
// Ports: clk, rst (async high), bus (slave: i_d in; q, o_rise, o_fall out).
module multi_debouncer
    import debounce_pkg::*;
#(
    parameter int   N_CH         = 4,
    parameter int   STABLE_TICKS = 16,
    parameter int   TICK_DIV     = 1000,
    parameter logic DEFAULT_D    = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    multi_debouncer_if.slave  bus
);

    logic            tick;
    logic [N_CH-1:0] q_v;
    logic [N_CH-1:0] rise_v;
    logic [N_CH-1:0] fall_v;

    // One tick for all channels keeps their sampling instants aligned.
    generate
        if (TICK_DIV == 1) begin : g_no_div
            assign tick = 1'b1;
        end else begin : g_div
            localparam int TW = clog2_min1(TICK_DIV);
            localparam logic [TW-1:0] TDIV_LAST = TW'(TICK_DIV - 1);

            logic [TW-1:0] tdiv;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    tdiv <= '0;
                end else if (tdiv == TDIV_LAST) begin
                    tdiv <= '0;
                end else begin
                    tdiv <= tdiv + 1'b1;
                end
            end

            assign tick = (tdiv == TDIV_LAST);
        end
    endgenerate

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            debounce_channel #(
                .STABLE_TICKS (STABLE_TICKS),
                .DEFAULT_D    (DEFAULT_D)
            ) u_ch (
                .clk    (clk),
                .rst    (rst),
                .i_tick (tick),
                .i_d    (bus.i_d[i]),
                .q      (q_v[i]),
                .o_rise (rise_v[i]),
                .o_fall (fall_v[i])
            );
        end
    endgenerate

    assign bus.q      = q_v;
    assign bus.o_rise = rise_v;
    assign bus.o_fall = fall_v;

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed testbench for multi_debouncer.
// dut1: STABLE_TICKS=4, TICK_DIV=1; dut2: STABLE_TICKS=4, TICK_DIV=8.
module tb_multi_debouncer;

    logic clk;
    logic rst;

    multi_debouncer_if #(.N_CH(4)) bus1 ();
    multi_debouncer_if #(.N_CH(4)) bus2 ();

    multi_debouncer #(
        .N_CH         (4),
        .STABLE_TICKS (4),
        .TICK_DIV     (1),
        .DEFAULT_D    (1'b0)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    multi_debouncer #(
        .N_CH         (4),
        .STABLE_TICKS (4),
        .TICK_DIV     (8),
        .DEFAULT_D    (1'b0)
    ) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total    = 0;

    typedef struct {
        logic [3:0] d;
        int         n;
        logic [3:0] q;
        logic [3:0] r;
        logic [3:0] f;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [11:0] act,
                       input logic [11:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive dut1, advance n edges, compare {q, o_rise, o_fall}.
    task automatic step(input string nm, input logic [3:0] d, input int n,
                        input logic [3:0] eq, input logic [3:0] er,
                        input logic [3:0] ef);
        bus1.i_d = d;
        edges(n);
        chk(nm, {bus1.q, bus1.o_rise, bus1.o_fall}, {eq, er, ef});
    endtask

    task automatic do_reset();
        bus1.i_d = 4'h0;
        bus2.i_d = 4'h0;
        rst = 1'b1;
        edges(2);
        rst = 1'b0;
    endtask

    initial begin
        int at;
        int bad;
        logic rise_at;
        logic tog;

        // Clean steps: window is 6 edges from drive to q edge.
        tbl[0] = '{4'h1, 5, 4'h0, 4'h0, 4'h0};
        tbl[1] = '{4'h1, 1, 4'h1, 4'h1, 4'h0};
        tbl[2] = '{4'h1, 1, 4'h1, 4'h0, 4'h0};
        tbl[3] = '{4'h3, 6, 4'h3, 4'h2, 4'h0};
        tbl[4] = '{4'h3, 1, 4'h3, 4'h0, 4'h0};
        tbl[5] = '{4'h0, 5, 4'h3, 4'h0, 4'h0};
        tbl[6] = '{4'h0, 1, 4'h0, 4'h0, 4'h3};
        tbl[7] = '{4'h0, 1, 4'h0, 4'h0, 4'h0};

        // Reset dominates with inputs high.
        rst = 1'b1;
        bus1.i_d = 4'hF;
        bus2.i_d = 4'h0;
        #1;
        for (int i = 0; i < 5; i++) begin
            edges(1);
            chk($sformatf("rst_hold%0d", i),
                {bus1.q, bus1.o_rise, bus1.o_fall}, 12'h000);
        end
        rst = 1'b0;
        step("rst_rel_pre", 4'hF, 5, 4'h0, 4'h0, 4'h0);
        step("rst_rel_q",   4'hF, 1, 4'hF, 4'hF, 4'h0);
        step("rst_rel_one", 4'hF, 1, 4'hF, 4'h0, 4'h0);

        do_reset();
        chk("rst_clear", {bus1.q, bus1.o_rise, bus1.o_fall}, 12'h000);

        for (int i = 0; i < 8; i++)
            step($sformatf("tbl%0d", i), tbl[i].d, tbl[i].n,
                 tbl[i].q, tbl[i].r, tbl[i].f);

        // Glitch of 3 clks on ch1.
        bus1.i_d = 4'h2;
        edges(3);
        bus1.i_d = 4'h0;
        for (int i = 0; i < 8; i++) begin
            edges(1);
            chk($sformatf("glitch%0d", i),
                {bus1.q, bus1.o_rise, bus1.o_fall}, 12'h000);
        end

        // Simultaneous opposite transitions.
        step("sim_set_pre", 4'h8, 5, 4'h0, 4'h0, 4'h0);
        step("sim_set",     4'h8, 1, 4'h8, 4'h8, 4'h0);
        step("sim_pre",     4'h4, 5, 4'h8, 4'h0, 4'h0);
        step("sim_edge",    4'h4, 1, 4'h4, 4'h4, 4'h8);
        step("sim_after",   4'h4, 1, 4'h4, 4'h0, 4'h0);

        // Reset mid-count discards progress.
        do_reset();
        bus1.i_d = 4'h1;
        edges(3);
        rst = 1'b1;
        edges(1);
        rst = 1'b0;
        chk("mid_rst", {bus1.q, bus1.o_rise, bus1.o_fall}, 12'h000);
        step("mid_pre", 4'h1, 5, 4'h0, 4'h0, 4'h0);
        step("mid_q",   4'h1, 1, 4'h1, 4'h1, 4'h0);

        // ch2 toggling every clk never qualifies.
        bad = 0;
        tog = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tog = ~tog;
            bus1.i_d = {1'b0, tog, 2'b01};
            edges(1);
            if (bus1.q !== 4'h1 || bus1.o_rise !== 4'h0
                || bus1.o_fall !== 4'h0) bad++;
        end
        chk("bounce1", 12'(bad), 12'd0);

        // Prescaled latency on dut2.
        do_reset();
        bus2.i_d = 4'h1;
        at = 0;
        rise_at = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            edges(1);
            if (at == 0 && bus2.q[0] === 1'b1) begin
                at = n;
                rise_at = bus2.o_rise[0];
            end
        end
        total++;
        if (at >= 27 && at <= 34) pass_cnt++;
        else $display("FAIL pre_lat: got %0d expected 27..34", at);
        chk("pre_rise", {11'd0, rise_at}, 12'd1);
        chk("pre_q", {bus2.q, bus2.o_rise, bus2.o_fall}, 12'h100);

        // ch1 toggling at tick rate on dut2 never qualifies.
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            bus2.i_d[1] = ~bus2.i_d[1];
            for (int j = 0; j < 8; j++) begin
                edges(1);
                if (bus2.q !== 4'h1 || bus2.o_rise !== 4'h0
                    || bus2.o_fall !== 4'h0) bad++;
            end
        end
        chk("bounce8", 12'(bad), 12'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
